// File: rtl/sprite_bounce_pkg.sv
// Shared constants for the bouncing-sprite renderer: sprite palette and start layout.
// Sprite i starts at (init_x0 + init_dx_x*i, init_y0 + init_dy_y*i).
package sprite_bounce_pkg;

    localparam int init_x0   = 32;
    localparam int init_dx_x = 64;
    localparam int init_y0   = 32;
    localparam int init_dy_y = 48;

    // RGB444, indexed by sprite number.
    localparam logic [11:0] palette [8] = '{
        12'hF00, 12'h0F0, 12'h00F, 12'hFF0,
        12'hF0F, 12'h0FF, 12'hF80, 12'hFFF
    };

endpackage

// File: rtl/sprite_motion.sv
// Position and direction of one sprite; steps and bounces off the screen edges once per frame tick.
// The start position and direction depend only on the sprite index.
module sprite_motion
    import sprite_bounce_pkg::*;
#(
    parameter int screen_width  = 640,
    parameter int screen_height = 480,
    parameter int w_x           = 10,
    parameter int w_y           = 9,
    parameter int sprite_w      = 32,
    parameter int sprite_h      = 32,
    parameter int step          = 2,
    parameter int idx           = 0
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           tick_i,
    input  logic           restart_i,
    input  logic           run_i,
    input  logic           fast_i,
    output logic [w_x-1:0] px_o,
    output logic [w_y-1:0] py_o
);

    localparam logic [w_x-1:0] px_init = w_x'(init_x0 + init_dx_x * idx);
    localparam logic [w_y-1:0] py_init = w_y'(init_y0 + init_dy_y * idx);
    localparam logic           dy_init = (idx % 2 == 1) ? 1'b0 : 1'b1;

    // All arithmetic is carried one bit wider than the coordinates so that edge sums cannot wrap.
    localparam logic [w_x:0] sx_norm = (w_x+1)'(step);
    localparam logic [w_x:0] sx_fast = (w_x+1)'(2 * step);
    localparam logic [w_x:0] x_size  = (w_x+1)'(sprite_w);
    localparam logic [w_x:0] x_lim   = (w_x+1)'(screen_width);
    localparam logic [w_x:0] x_max   = (w_x+1)'(screen_width - sprite_w);
    localparam logic [w_y:0] sy_norm = (w_y+1)'(step);
    localparam logic [w_y:0] sy_fast = (w_y+1)'(2 * step);
    localparam logic [w_y:0] y_size  = (w_y+1)'(sprite_h);
    localparam logic [w_y:0] y_lim   = (w_y+1)'(screen_height);
    localparam logic [w_y:0] y_max   = (w_y+1)'(screen_height - sprite_h);

    logic [w_x-1:0] px_q, px_d;
    logic [w_y-1:0] py_q, py_d;
    logic           dx_q, dx_d;
    logic           dy_q, dy_d;
    logic [w_x:0]   sx, px_ext;
    logic [w_y:0]   sy, py_ext;

    always_comb begin
        px_d   = px_q;
        py_d   = py_q;
        dx_d   = dx_q;
        dy_d   = dy_q;
        sx     = fast_i ? sx_fast : sx_norm;
        sy     = fast_i ? sy_fast : sy_norm;
        px_ext = {1'b0, px_q};
        py_ext = {1'b0, py_q};
        if (tick_i) begin
            if (restart_i) begin
                px_d = px_init;
                py_d = py_init;
                dx_d = 1'b1;
                dy_d = dy_init;
            end else if (run_i) begin
                if (dx_q) begin
                    if (px_ext + x_size + sx > x_lim) begin
                        px_d = w_x'(x_max);
                        dx_d = 1'b0;
                    end else begin
                        px_d = w_x'(px_ext + sx);
                    end
                end else if (px_ext < sx) begin
                    px_d = '0;
                    dx_d = 1'b1;
                end else begin
                    px_d = w_x'(px_ext - sx);
                end
                // The y axis is independent, so a corner reverses both directions in one tick.
                if (dy_q) begin
                    if (py_ext + y_size + sy > y_lim) begin
                        py_d = w_y'(y_max);
                        dy_d = 1'b0;
                    end else begin
                        py_d = w_y'(py_ext + sy);
                    end
                end else if (py_ext < sy) begin
                    py_d = '0;
                    dy_d = 1'b1;
                end else begin
                    py_d = w_y'(py_ext - sy);
                end
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            px_q <= px_init;
            py_q <= py_init;
            dx_q <= 1'b1;
            dy_q <= dy_init;
        end else begin
            px_q <= px_d;
            py_q <= py_d;
            dx_q <= dx_d;
            dy_q <= dy_d;
        end
    end

    assign px_o = px_q;
    assign py_o = py_q;

endmodule

// File: rtl/sprite_bounce_engine.sv
// Multi-sprite renderer: per-frame sprite motion, priority colour mux and per-frame overlap detection.
// Colour is combinational from x/y so it stays aligned with the timing generator's sync outputs.
module sprite_bounce_engine
    import sprite_bounce_pkg::*;
#(
    parameter int screen_width  = 640,
    parameter int screen_height = 480,
    parameter int w_x           = $clog2(screen_width),
    parameter int w_y           = $clog2(screen_height),
    parameter int n_sprites     = 4,
    parameter int sprite_w      = 32,
    parameter int sprite_h      = 32,
    parameter int step          = 2,
    parameter int w_red         = 4,
    parameter int w_green       = 4,
    parameter int w_blue        = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [w_x-1:0]       x,
    input  logic [w_y-1:0]       y,
    input  logic [n_sprites-1:0] run,
    input  logic                 restart,
    input  logic                 fast,
    output logic [w_red-1:0]     red,
    output logic [w_green-1:0]   green,
    output logic [w_blue-1:0]    blue,
    output logic                 collision
);

    localparam logic [w_x:0] x_size = (w_x+1)'(sprite_w);
    localparam logic [w_y:0] y_size = (w_y+1)'(sprite_h);

    logic                 tick_cond, tick_q, tick;
    logic [w_x-1:0]       px [n_sprites];
    logic [w_y-1:0]       py [n_sprites];
    logic                 visible;
    logic [n_sprites-1:0] hit;
    logic [2:0]           win_idx;
    logic                 any_hit;
    logic [11:0]          rgb;
    logic [3:0]           overlap_cnt;
    logic                 overlap;
    logic                 flag_q, flag_d;
    logic                 collision_q, collision_d;

    // Rising edge of the first-blanking-line condition; a slow pixel clock must still give one tick.
    assign tick_cond = (x == '0) && (y == w_y'(screen_height));
    assign tick      = tick_cond && !tick_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) tick_q <= 1'b1;
        else     tick_q <= tick_cond;
    end

    for (genvar i = 0; i < n_sprites; i++) begin : g_sprite
        sprite_motion #(
            .screen_width (screen_width),
            .screen_height(screen_height),
            .w_x          (w_x),
            .w_y          (w_y),
            .sprite_w     (sprite_w),
            .sprite_h     (sprite_h),
            .step         (step),
            .idx          (i)
        ) u_motion (
            .clk      (clk),
            .rst      (rst),
            .tick_i   (tick),
            .restart_i(restart),
            .run_i    (run[i]),
            .fast_i   (fast),
            .px_o     (px[i]),
            .py_o     (py[i])
        );
    end

    assign visible = ({1'b0, x} < (w_x+1)'(screen_width)) && ({1'b0, y} < (w_y+1)'(screen_height));

    always_comb begin
        hit         = '0;
        overlap_cnt = '0;
        for (int i = 0; i < n_sprites; i++) begin
            hit[i] = visible
                     && (x >= px[i]) && ({1'b0, x} < {1'b0, px[i]} + x_size)
                     && (y >= py[i]) && ({1'b0, y} < {1'b0, py[i]} + y_size);
            overlap_cnt = overlap_cnt + {3'b000, hit[i]};
        end
        overlap = overlap_cnt > 4'd1;
    end

    // Scanning from the top index down leaves the lowest covering sprite as the winner.
    always_comb begin
        win_idx = '0;
        any_hit = 1'b0;
        for (int i = n_sprites - 1; i >= 0; i--) begin
            if (hit[i]) begin
                win_idx = 3'(i);
                any_hit = 1'b1;
            end
        end
        rgb = any_hit ? palette[win_idx] : 12'h000;
    end

    assign red   = w_red'({rgb[11:8], {w_red{1'b0}}} >> 4);
    assign green = w_green'({rgb[7:4], {w_green{1'b0}}} >> 4);
    assign blue  = w_blue'({rgb[3:0], {w_blue{1'b0}}} >> 4);

    // An overlap seen on the tick cycle itself belongs to the frame that starts there.
    always_comb begin
        flag_d      = flag_q | overlap;
        collision_d = collision_q;
        if (tick) begin
            collision_d = flag_q;
            flag_d      = overlap;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            flag_q      <= 1'b0;
            collision_q <= 1'b0;
        end else begin
            flag_q      <= flag_d;
            collision_q <= collision_d;
        end
    end

    assign collision = collision_q;

endmodule

// File: tb/tb_sprite_bounce_engine.sv
// Randomised scoreboard bench for sprite_bounce_engine: a plain-arithmetic sprite model predicts
// pixel colours and the per-frame collision flag; a negedge monitor compares the DUT against it.
module tb_sprite_bounce_engine;

    localparam int W    = 640;
    localparam int H    = 480;
    localparam int N    = 4;
    localparam int SW   = 32;
    localparam int SH   = 32;
    localparam int STEP = 2;

    localparam logic [11:0] refPalette [8] = '{
        12'hF00, 12'h0F0, 12'h00F, 12'hFF0,
        12'hF0F, 12'h0FF, 12'hF80, 12'hFFF
    };

    typedef struct {
        int          pixX;
        int          pixY;
        logic [11:0] rgb;
        logic        coll;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst;
    logic [9:0] x;
    logic [8:0] y;
    logic [3:0] run;
    logic       restart;
    logic       fast;
    logic [3:0] red, green, blue;
    logic       collision;

    int   mPx [N];
    int   mPy [N];
    bit   mDx [N];
    bit   mDy [N];
    bit   mFlag, mColl, inReset;
    exp_t expQ[$];
    exp_t popped;
    bit   probeValid = 1'b0;
    bit   stimDone   = 1'b0;
    int   checks     = 0;
    int   failures   = 0;

    always #5 clk = ~clk;

    sprite_bounce_engine dut (
        .clk      (clk),
        .rst      (rst),
        .x        (x),
        .y        (y),
        .run      (run),
        .restart  (restart),
        .fast     (fast),
        .red      (red),
        .green    (green),
        .blue     (blue),
        .collision(collision)
    );

    function automatic void modelInit();
        for (int i = 0; i < N; i++) begin
            mPx[i] = 32 + 64 * i;
            mPy[i] = 32 + 48 * i;
            mDx[i] = 1'b1;
            mDy[i] = (i % 2 == 0);
        end
    endfunction

    // One axis of motion: clamp to the wall and reverse when the next step would leave the screen.
    function automatic int nextPos(input int p, input bit d, input int size, input int limit,
                                   input int s, output bit nd);
        nd = d;
        if (d) begin
            if (p + size + s > limit) begin
                nd = 1'b0;
                return limit - size;
            end
            return p + s;
        end
        if (p < s) begin
            nd = 1'b1;
            return 0;
        end
        return p - s;
    endfunction

    function automatic bit covers(input int i, input int cx, input int cy);
        return cx < W && cy < H && cx >= mPx[i] && cx < mPx[i] + SW && cy >= mPy[i] && cy < mPy[i] + SH;
    endfunction

    function automatic int coverCount(input int cx, input int cy);
        int n = 0;
        for (int i = 0; i < N; i++) if (covers(i, cx, cy)) n++;
        return n;
    endfunction

    function automatic logic [11:0] expectedRgb(input int cx, input int cy);
        for (int i = 0; i < N; i++) if (covers(i, cx, cy)) return refPalette[i];
        return 12'h000;
    endfunction

    task automatic drivePixel(input int cx, input int cy, input bit check);
        exp_t e;
        if (cx == 0 && cy == H) cy = H + 1;
        @(posedge clk);
        #1;
        x       = 10'(cx);
        y       = 9'(cy);
        run     = 4'($urandom);
        fast    = 1'($urandom);
        restart = 1'($urandom);
        if (!inReset && coverCount(cx, cy) >= 2) mFlag = 1'b1;
        if (check) begin
            e.pixX = cx;
            e.pixY = cy;
            e.rgb  = expectedRgb(cx, cy);
            e.coll = mColl;
            expQ.push_back(e);
        end
        probeValid = check;
    endtask

    task automatic doTick(input logic [3:0] runV, input bit fastV, input bit restartV, input int hold);
        int s;
        bit nd;
        @(posedge clk);
        #1;
        x          = '0;
        y          = 9'(H);
        run        = runV;
        fast       = fastV;
        restart    = restartV;
        probeValid = 1'b0;
        repeat (hold) @(posedge clk);
        mColl = mFlag;
        mFlag = 1'b0;
        s     = fastV ? 2 * STEP : STEP;
        if (restartV) begin
            modelInit();
        end else begin
            for (int i = 0; i < N; i++) begin
                if (runV[i]) begin
                    mPx[i] = nextPos(mPx[i], mDx[i], SW, W, s, nd);
                    mDx[i] = nd;
                    mPy[i] = nextPos(mPy[i], mDy[i], SH, H, s, nd);
                    mDy[i] = nd;
                end
            end
        end
    endtask

    task automatic pulseReset();
        @(posedge clk);
        #3;
        rst     = 1'b1;
        inReset = 1'b1;
        modelInit();
        mFlag = 1'b0;
        mColl = 1'b0;
        drivePixel(40, 40, 1'b1);
        drivePixel(0, 0, 1'b1);
        drivePixel(224, 176, 1'b1);
        drivePixel(223, 176, 1'b1);
        @(posedge clk);
        #1;
        x          = '0;
        y          = 9'(H);
        rst        = 1'b0;
        inReset    = 1'b0;
        probeValid = 1'b0;
        repeat (3) @(posedge clk);
    endtask

    // One frame: probe edges of a sprite, every overlap region and a couple of random pixels, then tick.
    task automatic applyStimulus(input logic [3:0] runV, input bit fastV, input bit restartV, input int hold);
        int s = $urandom_range(0, N - 1);
        int bx = mPx[s];
        int by = mPy[s];
        drivePixel(bx, by, 1'b1);
        if (bx > 0) drivePixel(bx - 1, by, 1'b1);
        drivePixel(bx + SW - 1, by + SH - 1, 1'b1);
        drivePixel(bx + SW, by + SH - 1, 1'b1);
        drivePixel(bx, by + SH, 1'b1);
        for (int i = 0; i < N; i++) begin
            for (int j = i + 1; j < N; j++) begin
                int ix = (mPx[i] > mPx[j]) ? mPx[i] : mPx[j];
                int iy = (mPy[i] > mPy[j]) ? mPy[i] : mPy[j];
                if (covers(i, ix, iy) && covers(j, ix, iy)) drivePixel(ix, iy, 1'b1);
            end
        end
        repeat (2) drivePixel($urandom_range(0, 700), $urandom_range(0, 511), 1'b1);
        doTick(runV, fastV, restartV, hold);
    endtask

    task automatic checkOutput(input exp_t e);
        checks += 2;
        if ({red, green, blue} !== e.rgb) begin
            failures++;
            $display("[TB] FAIL colour at (%0d,%0d): got %03h expected %03h",
                     e.pixX, e.pixY, {red, green, blue}, e.rgb);
        end
        if (collision !== e.coll) begin
            failures++;
            $display("[TB] FAIL collision at (%0d,%0d): got %0b expected %0b",
                     e.pixX, e.pixY, collision, e.coll);
        end
    endtask

    always @(negedge clk) begin
        if (probeValid) begin
            if (expQ.size() == 0) begin
                checks++;
                failures++;
                $display("[TB] FAIL scoreboard: probe with no expected entry");
            end else begin
                popped = expQ.pop_front();
                checkOutput(popped);
            end
        end
        if (stimDone) begin
            checks++;
            if (expQ.size() != 0) begin
                failures++;
                $display("[TB] FAIL scoreboard drain: got %0d left expected 0", expQ.size());
            end
            $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
            $finish;
        end
    end

    initial begin
        #3_000_000;
        $display("[TB] FAIL watchdog: stimulus did not complete");
        $fatal(1, "[TB] timeout");
    end

    initial begin
        rst     = 1'b1;
        x       = 10'd5;
        y       = 9'd5;
        run     = '0;
        fast    = 1'b0;
        restart = 1'b0;
        inReset = 1'b1;
        modelInit();
        mFlag = 1'b0;
        mColl = 1'b0;
        $display("[TB] reset layout and no tick straight after reset");
        pulseReset();
        $display("[TB] single-sprite motion with a 4-cycle tick hold");
        applyStimulus(4'b0001, 1'b0, 1'b0, 4);
        applyStimulus(4'b0000, 1'b0, 1'b0, 1);
        $display("[TB] sprite 0 sweeping through sprite 1");
        for (int f = 0; f < 60; f++) applyStimulus(4'b0001, 1'b0, 1'b0, $urandom_range(1, 4));
        $display("[TB] mid-frame reset");
        pulseReset();
        $display("[TB] randomised frames");
        for (int f = 0; f < 600; f++) begin
            logic [3:0] r;
            for (int b = 0; b < N; b++) r[b] = ($urandom_range(0, 3) != 0);
            applyStimulus(r, 1'($urandom_range(0, 1)), ($urandom_range(0, 99) == 0), $urandom_range(1, 4));
        end
        $display("[TB] restart with all sprites running");
        applyStimulus(4'b1111, 1'b1, 1'b1, 2);
        applyStimulus(4'b0000, 1'b0, 1'b0, 1);
        @(posedge clk);
        #1;
        probeValid = 1'b0;
        stimDone   = 1'b1;
    end

endmodule
